// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters and the shared
// memory port. The arbiter takes the slave view; the environment (fetch unit,
// load/store unit and memory) takes the master view.
//
// Handshakes: a requester raises *_req_i with its fields stable and keeps them
// until the arbiter returns a one-cycle *_gnt_o (fetch may also abandon via
// flush_i). On the memory side mem_req_o and the mem_* fields stay stable until
// mem_ready_i is seen high on a rising edge; exactly one mem_rvalid_i follows,
// no earlier than the next cycle.
//
// dbg_state_o encodes the arbiter state: 0 = IDLE, 1 = REQ, 2 = WAIT.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        flush_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;

  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic [1:0]  dbg_state_o;
  logic [7:0]  dbg_starve_o;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output dbg_state_o, dbg_starve_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  dbg_state_o, dbg_starve_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: instruction fetch vs load/store. One transaction
// at a time (IDLE -> REQ -> WAIT). Load/store wins ties unless fetch has lost
// STARVE_LIMIT consecutive arbitrations while waiting. flush_i lets fetch
// abandon its transaction; the memory access still completes silently.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk_i,
  input logic          rstn_i,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;

  logic               if_want;
  logic               if_win;
  logic               drop_eff;

  // Next-state: arbitration in IDLE, memory handshake in REQ/WAIT, flush tracking.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // A fetch request raised together with flush is treated as absent.
    if_want     = bus.if_req_i & ~bus.flush_i;
    if_win      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if_win = if_want & (~bus.ls_req_i | (starve_q == CNT_MAX));
        if (if_win) begin
          state_d     = ST_REQ;
          owner_d     = OWN_IF;
          drop_d      = 1'b0;
          starve_d    = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'hF;
          mem_addr_d  = bus.if_addr_i;
          mem_wdata_d = 32'h0;
        end else if (bus.ls_req_i) begin
          state_d     = ST_REQ;
          owner_d     = OWN_LS;
          drop_d      = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.ls_we_i;
          mem_be_d    = bus.ls_be_i;
          mem_addr_d  = bus.ls_addr_i;
          mem_wdata_d = bus.ls_wdata_i;
          if (!if_want) begin
            starve_d = '0;
          end else if (starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
          end
        end else begin
          starve_d = '0;
        end
      end
      ST_REQ: begin
        if (owner_q == OWN_IF && bus.flush_i) begin
          drop_d = 1'b1;
        end
        if (bus.mem_ready_i) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (owner_q == OWN_IF && bus.flush_i) begin
          drop_d = 1'b1;
        end
        if (bus.mem_rvalid_i) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transaction-field registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // A flush arriving in the same cycle as ready/rvalid already hides the pulse.
  assign drop_eff = drop_q | bus.flush_i;

  assign bus.if_gnt_o    = (state_q == ST_REQ)  & bus.mem_ready_i  & (owner_q == OWN_IF) & ~drop_eff;
  assign bus.ls_gnt_o    = (state_q == ST_REQ)  & bus.mem_ready_i  & (owner_q == OWN_LS);
  assign bus.if_rvalid_o = (state_q == ST_WAIT) & bus.mem_rvalid_i & (owner_q == OWN_IF) & ~drop_eff;
  assign bus.ls_rvalid_o = (state_q == ST_WAIT) & bus.mem_rvalid_i & (owner_q == OWN_LS);
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.ls_rdata_o  = bus.mem_rdata_i;

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

  assign bus.dbg_state_o  = state_q;
  assign bus.dbg_starve_o = 8'(starve_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic clk;
  logic rstn;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  // One outstanding transaction: who owns it, whether memory accepted it,
  // whether fetch abandoned it, and the fields it must present.
  bit          m_busy, m_acc, m_is_if, m_drop;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  int          m_streak;
  int          m_age;

  // stimulus knobs
  int          ready_dly, rsp_dly;
  bit          spur_en, rand_mode, ls_continuous, force_rvalid, rdata_fix;
  logic [31:0] rdata_val;

  // observed pulse counters per scenario
  int n_cyc;
  int obs_if_gnt, obs_ls_gnt, obs_if_rv, obs_ls_rv;
  int first_if_rv, first_ls_rv, ls_before_if;

  task automatic clear_obs();
    obs_if_gnt = 0; obs_ls_gnt = 0; obs_if_rv = 0; obs_ls_rv = 0;
    first_if_rv = -1; first_ls_rv = -1; ls_before_if = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_if();
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic new_ls();
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'($urandom_range(0, 1));
    bus.ls_be_i    = 4'($urandom_range(0, 15));
    bus.ls_addr_i  = $urandom() & 32'hFFFF_FFFC;
    bus.ls_wdata_i = $urandom();
  endtask

  task automatic quiet_inputs();
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0; bus.flush_i = 1'b0;
    bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_be_i = 4'h0;
    bus.ls_addr_i = 32'h0; bus.ls_wdata_i = 32'h0;
    bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;
  endtask

  // Called shortly after a falling edge: holds reset for one rising edge,
  // then checks the post-reset output values.
  task automatic do_reset();
    rstn = 1'b0;
    quiet_inputs();
    @(negedge clk);
    rstn = 1'b1;
    m_busy = 0; m_acc = 0; m_drop = 0; m_streak = 0; m_age = 0;
    exp_q.delete();
    #1;
    check("rst_mem_req",   32'(bus.mem_req_o),   0);
    check("rst_mem_we",    32'(bus.mem_we_o),    0);
    check("rst_mem_be",    32'(bus.mem_be_o),    0);
    check("rst_mem_addr",  bus.mem_addr_o,       0);
    check("rst_mem_wdata", bus.mem_wdata_o,      0);
    check("rst_if_gnt",    32'(bus.if_gnt_o),    0);
    check("rst_ls_gnt",    32'(bus.ls_gnt_o),    0);
    check("rst_state",     32'(bus.dbg_state_o), 0);
    check("rst_starve",    32'(bus.dbg_starve_o), 0);
  endtask

  // One clock cycle: memory-side drive, output checks against the model,
  // model advance, then requester reactions after the next falling edge.
  task automatic cycle();
    bit e_req, e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, done, hide, if_want;
    logic [31:0] exp_d;

    bus.mem_ready_i  = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = rdata_fix ? rdata_val : $urandom();
    if (m_busy && !m_acc) begin
      bus.mem_ready_i = (m_age >= ready_dly);
    end else if (m_busy && m_acc) begin
      if (m_age >= rsp_dly) begin
        bus.mem_rvalid_i = 1'b1;
        exp_q.push_back(bus.mem_rdata_i);
      end
    end else begin
      bus.mem_ready_i  = spur_en && ($urandom_range(0, 1) == 1);
      bus.mem_rvalid_i = force_rvalid || (spur_en && $urandom_range(0, 3) == 0);
    end
    force_rvalid = 1'b0;

    #1;
    e_req    = m_busy && !m_acc;
    hide     = m_drop || bus.flush_i;
    e_if_gnt = e_req && bus.mem_ready_i && m_is_if && !hide;
    e_ls_gnt = e_req && bus.mem_ready_i && !m_is_if;
    done     = m_busy && m_acc && bus.mem_rvalid_i;
    e_if_rv  = done && m_is_if && !hide;
    e_ls_rv  = done && !m_is_if;

    check("mem_req",    32'(bus.mem_req_o),   32'(e_req));
    check("if_gnt",     32'(bus.if_gnt_o),    32'(e_if_gnt));
    check("ls_gnt",     32'(bus.ls_gnt_o),    32'(e_ls_gnt));
    check("if_rvalid",  32'(bus.if_rvalid_o), 32'(e_if_rv));
    check("ls_rvalid",  32'(bus.ls_rvalid_o), 32'(e_ls_rv));
    check("starve_cnt", 32'(bus.dbg_starve_o), 32'(m_streak));
    if (e_req) begin
      check("mem_we",    32'(bus.mem_we_o), 32'(m_we));
      check("mem_be",    32'(bus.mem_be_o), 32'(m_be));
      check("mem_addr",  bus.mem_addr_o,    m_addr);
      check("mem_wdata", bus.mem_wdata_o,   m_wdata);
    end
    if (done) begin
      exp_d = exp_q.pop_front();
      if (e_if_rv) check("if_rdata", bus.if_rdata_o, exp_d);
      if (e_ls_rv) check("ls_rdata", bus.ls_rdata_o, exp_d);
    end

    if (bus.if_gnt_o) begin
      if (ls_before_if < 0) ls_before_if = obs_ls_gnt;
      obs_if_gnt++;
    end
    if (bus.ls_gnt_o) obs_ls_gnt++;
    if (bus.if_rvalid_o) begin
      if (first_if_rv < 0) first_if_rv = n_cyc;
      obs_if_rv++;
    end
    if (bus.ls_rvalid_o) begin
      if (first_ls_rv < 0) first_ls_rv = n_cyc;
      obs_ls_rv++;
    end

    // model advance
    if (!m_busy) begin
      if_want = bus.if_req_i && !bus.flush_i;
      if (if_want && (!bus.ls_req_i || m_streak >= STARVE_LIMIT)) begin
        m_busy = 1; m_acc = 0; m_drop = 0; m_age = 0; m_is_if = 1;
        m_we = 1'b0; m_be = 4'hF; m_addr = bus.if_addr_i; m_wdata = 32'h0;
        m_streak = 0;
      end else if (bus.ls_req_i) begin
        m_busy = 1; m_acc = 0; m_drop = 0; m_age = 0; m_is_if = 0;
        m_we = bus.ls_we_i; m_be = bus.ls_be_i; m_addr = bus.ls_addr_i; m_wdata = bus.ls_wdata_i;
        m_streak = if_want ? ((m_streak < STARVE_LIMIT) ? m_streak + 1 : STARVE_LIMIT) : 0;
      end else begin
        m_streak = 0;
      end
    end else begin
      if (m_is_if && bus.flush_i) m_drop = 1;
      m_age++;
      if (!m_acc && bus.mem_ready_i) begin
        m_acc = 1;
        m_age = 0;
      end else if (done) begin
        m_busy = 0;
      end
    end
    n_cyc++;

    @(negedge clk);
    if (e_if_gnt || bus.flush_i) bus.if_req_i = 1'b0;
    if (e_ls_gnt) begin
      bus.ls_req_i = 1'b0;
      if (ls_continuous) new_ls();
    end
    bus.flush_i = 1'b0;
    if (rand_mode) begin
      if (!bus.if_req_i && $urandom_range(0, 2) == 0) new_if();
      if (!bus.ls_req_i && $urandom_range(0, 1) == 0) new_ls();
      bus.flush_i = ($urandom_range(0, 11) == 0);
      ready_dly   = $urandom_range(0, 3);
      rsp_dly     = $urandom_range(0, 3);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    rstn = 1'b0;
    quiet_inputs();
    n_cyc = 0;
    ready_dly = 0; rsp_dly = 0;
    spur_en = 0; rand_mode = 0; ls_continuous = 0; force_rvalid = 0;
    rdata_fix = 0; rdata_val = 32'h0;
    clear_obs();
    @(negedge clk);
    do_reset();

    // Fetch alone: gnt at T1, rvalid with data at T2.
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0000_0010;
    rdata_fix = 1; rdata_val = 32'h0000_0013;
    clear_obs();
    repeat (4) cycle();
    check("t1_if_gnt_cnt", obs_if_gnt, 1);
    check("t1_if_rv_cnt",  obs_if_rv,  1);
    rdata_fix = 0;

    // Both request: load/store store first, fetch next.
    bus.ls_req_i = 1'b1; bus.ls_we_i = 1'b1; bus.ls_be_i = 4'b0011;
    bus.ls_addr_i = 32'h100; bus.ls_wdata_i = 32'hDEAD_BEEF;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
    clear_obs();
    repeat (8) cycle();
    check("t2_ls_rv_cnt", obs_ls_rv, 1);
    check("t2_if_rv_cnt", obs_if_rv, 1);
    check("t2_ls_first",  32'(first_ls_rv >= 0 && first_ls_rv < first_if_rv), 1);

    // Starvation: continuous load/store, fetch waits.
    clear_obs();
    ls_continuous = 1;
    new_ls();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
    for (int i = 0; i < 60 && obs_if_gnt == 0; i++) cycle();
    check("t3_ls_wins_before_if", ls_before_if, STARVE_LIMIT);
    check("t3_starve_after_if",   32'(bus.dbg_starve_o), 0);
    ls_continuous = 0;
    repeat (12) cycle();

    // Flush while fetch sits in REQ with memory stalling.
    bus.ls_req_i = 1'b0; bus.if_req_i = 1'b0;
    repeat (8) cycle();
    clear_obs();
    ready_dly = 3;
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h80;
    cycle();
    cycle();
    bus.flush_i = 1'b1;
    cycle();
    new_ls();
    repeat (14) cycle();
    check("t4_if_gnt_cnt", obs_if_gnt, 0);
    check("t4_if_rv_cnt",  obs_if_rv,  0);
    check("t4_ls_rv_cnt",  obs_ls_rv,  1);

    // Reset while waiting for the response, then a late rvalid.
    ready_dly = 0; rsp_dly = 10;
    new_ls();
    repeat (3) cycle();
    do_reset();
    rsp_dly = 0;
    clear_obs();
    force_rvalid = 1;
    cycle();
    check("t5_ls_rv_cnt", obs_ls_rv, 0);
    check("t5_if_rv_cnt", obs_if_rv, 0);
    check("t5_state",     32'(bus.dbg_state_o), 0);

    // Long ready and response latencies.
    ready_dly = 5; rsp_dly = 5;
    clear_obs();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'hC0;
    new_ls();
    repeat (30) cycle();
    check("t6_if_gnt_cnt", obs_if_gnt, 1);
    check("t6_ls_gnt_cnt", obs_ls_gnt, 1);
    check("t6_if_rv_cnt",  obs_if_rv,  1);
    check("t6_ls_rv_cnt",  obs_ls_rv,  1);

    // Randomized traffic with flushes, spurious memory strobes and resets.
    rand_mode = 1; spur_en = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle();
    end
    rand_mode = 0; spur_en = 0;
    bus.if_req_i = 1'b0; bus.ls_req_i = 1'b0; bus.flush_i = 1'b0;
    ready_dly = 0; rsp_dly = 0;
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
